// File: rtl/fifo_pkg.sv
// Shared helpers for multi-lane FIFOs: lane counting, the all-ones "no element"
// filler and a counter-width helper that stays legal for a depth of 1.
package fifo_pkg;

  localparam int MAX_LANES  = 4;
  localparam int MAX_ELEM_W = 1024;

  function automatic logic [MAX_ELEM_W-1:0] elem_none(input int width);
    logic [MAX_ELEM_W-1:0] v;
    v = '0;
    for (int b = 0; b < MAX_ELEM_W; b++) v[b] = (b < width);
    return v;
  endfunction

  function automatic int popcount(input logic [MAX_LANES-1:0] v, input int n);
    int c;
    c = 0;
    for (int i = 0; i < MAX_LANES; i++) if (i < n && v[i]) c++;
    return c;
  endfunction

  function automatic int lead_ones(input logic [MAX_LANES-1:0] v, input int n);
    int  c;
    bit  run;
    c   = 0;
    run = 1'b1;
    for (int i = 0; i < MAX_LANES; i++) begin
      if (run && i < n && v[i]) c++;
      else run = 1'b0;
    end
    return c;
  endfunction

  function automatic int clog2_safe(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fifo_lane_compact.sv
// Ranks valid write lanes and accepts those whose rank fits in the registered
// free count, so accepted lanes always land contiguously from the tail.
module fifo_lane_compact
  import fifo_pkg::*;
#(
  parameter int W_PORTS   = 2,
  parameter int CNT_WIDTH = 5
) (
  input  logic [W_PORTS-1:0]       w_val,
  input  logic [CNT_WIDTH-1:0]     free,
  output logic [W_PORTS-1:0][1:0]  rank,
  output logic [W_PORTS-1:0]       w_rdy,
  output logic [W_PORTS-1:0]       accept,
  output logic [2:0]               nw
);

  always_comb begin
    int cnt;
    cnt    = 0;
    rank   = '0;
    w_rdy  = '0;
    accept = '0;
    for (int i = 0; i < W_PORTS; i++) begin
      rank[i]   = 2'(cnt);
      w_rdy[i]  = (cnt < int'(free));
      accept[i] = w_val[i] & w_rdy[i];
      cnt       = cnt + int'(w_val[i]);
    end
    nw = 3'(popcount(MAX_LANES'(accept), W_PORTS));
  end

endmodule

// File: rtl/fifo_mw_mr.sv
// Multi-write, multi-read first-word-fall-through FIFO with compacted write
// lanes, thermometer pops and an optional same-cycle empty bypass.
module fifo_mw_mr
  import fifo_pkg::*;
#(
  parameter int FIFO_WIDTH = 64,
  parameter int FIFO_DEPTH = 16,
  parameter int W_PORTS    = 2,
  parameter int R_PORTS    = 2,
  parameter int BYPASS     = 1,
  parameter int CNT_WIDTH  = clog2_safe(FIFO_DEPTH) + 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [W_PORTS-1:0]            w_val,
  input  logic [W_PORTS*FIFO_WIDTH-1:0] w_data,
  output logic [W_PORTS-1:0]            w_rdy,
  input  logic [R_PORTS-1:0]            r_val,
  output logic [R_PORTS*FIFO_WIDTH-1:0] r_data,
  output logic [R_PORTS-1:0]            r_avail,
  output logic [CNT_WIDTH-1:0]          size,
  output logic [CNT_WIDTH-1:0]          free,
  output logic                          full,
  output logic                          empty
);

  localparam int AW = clog2_safe(FIFO_DEPTH);
  localparam logic [FIFO_WIDTH-1:0] NONE = FIFO_WIDTH'(elem_none(FIFO_WIDTH));

  logic [FIFO_WIDTH-1:0]     mem [FIFO_DEPTH];
  logic [AW-1:0]             head, tail;
  logic [CNT_WIDTH-1:0]      used, used_next;
  logic [W_PORTS-1:0][1:0]   rank;
  logic [W_PORTS-1:0]        accept;
  logic [2:0]                nw, nr;
  logic                      r_val_therm;

  fifo_lane_compact #(
    .W_PORTS   (W_PORTS),
    .CNT_WIDTH (CNT_WIDTH)
  ) u_compact (
    .w_val  (w_val),
    .free   (free),
    .rank   (rank),
    .w_rdy  (w_rdy),
    .accept (accept),
    .nw     (nw)
  );

  // Lanes past the stored entries are served from this cycle's accepted writes.
  always_comb begin
    r_data  = '0;
    r_avail = '0;
    for (int j = 0; j < R_PORTS; j++) begin
      r_data[j*FIFO_WIDTH +: FIFO_WIDTH] = NONE;
      if (j < int'(used)) begin
        r_avail[j] = 1'b1;
        r_data[j*FIFO_WIDTH +: FIFO_WIDTH] = mem[head + AW'(j)];
      end else if (BYPASS != 0 && j < int'(used) + int'(nw)) begin
        r_avail[j] = 1'b1;
        for (int i = 0; i < W_PORTS; i++) begin
          if (accept[i] && int'(rank[i]) == j - int'(used))
            r_data[j*FIFO_WIDTH +: FIFO_WIDTH] = w_data[i*FIFO_WIDTH +: FIFO_WIDTH];
        end
      end
    end
    nr = 3'(lead_ones(MAX_LANES'(r_val & r_avail), R_PORTS));
  end

  assign used_next   = used + CNT_WIDTH'(nw) - CNT_WIDTH'(nr);
  assign size        = used;
  assign r_val_therm = ((r_val & (r_val + R_PORTS'(1))) == '0);

  always_ff @(posedge clk) begin
    for (int i = 0; i < W_PORTS; i++) begin
      if (accept[i]) mem[tail + AW'(rank[i])] <= w_data[i*FIFO_WIDTH +: FIFO_WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      used  <= '0;
      free  <= CNT_WIDTH'(FIFO_DEPTH);
      full  <= 1'b0;
      empty <= 1'b1;
    end else begin
      head  <= head + AW'(nr);
      tail  <= tail + AW'(nw);
      used  <= used_next;
      free  <= CNT_WIDTH'(FIFO_DEPTH) - used_next;
      full  <= (used_next == CNT_WIDTH'(FIFO_DEPTH));
      empty <= (used_next == '0);
    end
  end

  // A gapped r_val only pops its leading run; flag it without stopping simulation.
  always_ff @(posedge clk) begin
    assert (rst || r_val_therm)
      else $warning("r_val not thermometer-coded: %b", r_val);
  end

endmodule

// File: tb/tb_fifo_mw_mr.sv
// Directed bench for fifo_mw_mr: one storage-only instance and one bypass instance.
module tb_fifo_mw_mr;

  localparam int FW = 64;
  localparam logic [127:0] ONES2 = {128{1'b1}};

  logic         clk;
  logic         rst;

  logic [1:0]   nb_wv, nb_wr, nb_rv, nb_ra;
  logic [127:0] nb_wd, nb_rd;
  logic [4:0]   nb_size, nb_free;
  logic         nb_full, nb_empty;

  logic [1:0]   by_wv, by_wr, by_rv, by_ra;
  logic [127:0] by_wd, by_rd;
  logic [4:0]   by_size, by_free;
  logic         by_full, by_empty;

  int total;
  int bad;

  fifo_mw_mr #(.FIFO_WIDTH(FW), .FIFO_DEPTH(16), .W_PORTS(2), .R_PORTS(2), .BYPASS(0)) u_nb (
    .clk(clk), .rst(rst), .w_val(nb_wv), .w_data(nb_wd), .w_rdy(nb_wr),
    .r_val(nb_rv), .r_data(nb_rd), .r_avail(nb_ra),
    .size(nb_size), .free(nb_free), .full(nb_full), .empty(nb_empty)
  );

  fifo_mw_mr #(.FIFO_WIDTH(FW), .FIFO_DEPTH(16), .W_PORTS(2), .R_PORTS(2), .BYPASS(1)) u_by (
    .clk(clk), .rst(rst), .w_val(by_wv), .w_data(by_wd), .w_rdy(by_wr),
    .r_val(by_rv), .r_data(by_rd), .r_avail(by_ra),
    .size(by_size), .free(by_free), .full(by_full), .empty(by_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    nb_wv = '0; nb_rv = '0; nb_wd = '0;
    by_wv = '0; by_rv = '0; by_wd = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    nb_wv = '0; nb_rv = '0; nb_wd = '0;
    by_wv = '0; by_rv = '0; by_wd = '0;
    cyc();
    cyc();
    rst = 1'b0;

    chk("rst_size",  nb_size,  5'd0);
    chk("rst_free",  nb_free,  5'd16);
    chk("rst_empty", nb_empty, 1'b1);
    chk("rst_full",  nb_full,  1'b0);
    chk("rst_avail", nb_ra,    2'b00);
    chk("rst_rdata", nb_rd,    ONES2);

    // bypass: write and pop the same word in one cycle
    by_wv = 2'b01; by_wd = {64'h0, 64'h5}; by_rv = 2'b01;
    #1;
    chk("byp_avail", by_ra, 2'b01);
    chk("byp_lane0", by_rd[63:0], 64'h5);
    chk("byp_lane1", by_rd[127:64], {64{1'b1}});
    cyc();
    chk("byp_size",  by_size,  5'd0);
    chk("byp_empty", by_empty, 1'b1);
    // gapped pop request pops nothing
    by_wv = 2'b11; by_wd = {64'h7, 64'h6}; by_rv = 2'b10;
    #1;
    chk("gap_avail", by_ra, 2'b11);
    chk("gap_lane0", by_rd[63:0], 64'h6);
    cyc();
    chk("gap_size",  by_size, 5'd2);
    chk("gap_head0", by_rd[63:0], 64'h6);
    chk("gap_head1", by_rd[127:64], 64'h7);

    // storage-only: two-lane write, visible next cycle
    nb_wv = 2'b11; nb_wd = {64'hB, 64'hA};
    #1;
    chk("w2_rdy",     nb_wr, 2'b11);
    chk("w2_nobyp",   nb_ra, 2'b00);
    cyc();
    chk("w2_avail",   nb_ra, 2'b11);
    chk("w2_lane0",   nb_rd[63:0], 64'hA);
    chk("w2_lane1",   nb_rd[127:64], 64'hB);
    chk("w2_size",    nb_size, 5'd2);
    nb_rv = 2'b11;
    cyc();
    chk("p2_empty",   nb_empty, 1'b1);
    chk("p2_size",    nb_size, 5'd0);

    // compaction: only lane 1 valid
    do_reset();
    nb_wv = 2'b10; nb_wd = {64'hC, 64'h0};
    cyc();
    chk("cmp_size",  nb_size, 5'd1);
    chk("cmp_avail", nb_ra, 2'b01);
    chk("cmp_lane0", nb_rd[63:0], 64'hC);
    chk("cmp_idx0",  u_nb.mem[0], 64'hC);

    // fill to 15, then a two-lane write with one slot left
    do_reset();
    for (int k = 0; k < 7; k++) begin
      nb_wv = 2'b11; nb_wd = {64'(2*k+1), 64'(2*k)};
      cyc();
    end
    nb_wv = 2'b01; nb_wd = {64'hDEAD, 64'd14};
    cyc();
    chk("f15_size", nb_size, 5'd15);
    chk("f15_free", nb_free, 5'd1);
    nb_wv = 2'b11; nb_wd = {64'd99, 64'd15};
    #1;
    chk("f15_rdy", nb_wr, 2'b01);
    cyc();
    chk("f16_size", nb_size, 5'd16);
    chk("f16_full", nb_full, 1'b1);
    chk("f16_free", nb_free, 5'd0);
    chk("f16_head", nb_rd[63:0], 64'd0);
    nb_wv = 2'b11; nb_wd = {64'd101, 64'd100}; nb_rv = 2'b01;
    #1;
    chk("full_rdy", nb_wr, 2'b00);
    cyc();
    chk("fr_size", nb_size, 5'd15);
    chk("fr_full", nb_full, 1'b0);
    for (int k = 0; k < 7; k++) begin
      nb_rv = 2'b11;
      #1;
      chk("drain_l0", nb_rd[63:0],   64'(2*k+1));
      chk("drain_l1", nb_rd[127:64], 64'(2*k+2));
      cyc();
    end
    nb_rv = 2'b01;
    #1;
    chk("drain_last", nb_rd[63:0], 64'd15);
    cyc();
    chk("drain_empty", nb_empty, 1'b1);

    // wrap across index 15 -> 0
    do_reset();
    for (int k = 0; k < 7; k++) begin
      nb_wv = 2'b11; nb_wd = {64'(k), 64'(k)};
      cyc();
    end
    for (int k = 0; k < 7; k++) begin
      nb_rv = 2'b11;
      cyc();
    end
    chk("wr_pre_size", nb_size, 5'd0);
    nb_wv = 2'b11; nb_wd = {64'h51, 64'h50};
    cyc();
    nb_wv = 2'b11; nb_wd = {64'h53, 64'h52};
    cyc();
    chk("wr_size", nb_size, 5'd4);
    nb_rv = 2'b11;
    #1;
    chk("wr_l0a", nb_rd[63:0],   64'h50);
    chk("wr_l1a", nb_rd[127:64], 64'h51);
    cyc();
    nb_rv = 2'b11;
    #1;
    chk("wr_l0b", nb_rd[63:0],   64'h52);
    chk("wr_l1b", nb_rd[127:64], 64'h53);
    cyc();
    chk("wr_empty", nb_empty, 1'b1);
    chk("wr_head",  u_nb.head, 4'd2);
    chk("wr_tail",  u_nb.tail, 4'd2);

    // reset with 5 entries held
    nb_wv = 2'b11; nb_wd = {64'h2, 64'h1};
    cyc();
    nb_wv = 2'b11; nb_wd = {64'h4, 64'h3};
    cyc();
    nb_wv = 2'b01; nb_wd = {64'h0, 64'h5};
    cyc();
    chk("r5_size", nb_size, 5'd5);
    do_reset();
    chk("r5_after_size",  nb_size,  5'd0);
    chk("r5_after_free",  nb_free,  5'd16);
    chk("r5_after_empty", nb_empty, 1'b1);
    chk("r5_after_avail", nb_ra,    2'b00);
    chk("r5_after_rdata", nb_rd,    ONES2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fifo_mw_mr.md
Name: fifo_mw_mr

Overview:
- Parametrised multi-write, multi-read first-word-fall-through FIFO; successor to the two-write-port FIFO used by the TCP engine queues.
- Accepts up to W_PORTS pushes and serves up to R_PORTS pops per cycle, with per-lane ready backpressure and true full-depth occupancy.
- Offers an optional same-cycle empty bypass.
- Sits between producers that retire several descriptors per cycle, such as segment/ACK generators, and multi-issue consumers.

Parameters:
- FIFO_WIDTH, 64: data bits per entry.
- FIFO_DEPTH, 16: number of entries. Must be a power of two and at least max(W_PORTS, R_PORTS).
- W_PORTS, 2: write lanes per cycle, 1..4.
- R_PORTS, 2: read lanes per cycle, 1..4.
- BYPASS, 1: 1 means writes accepted while a lane is unavailable in storage are visible to reads in the same cycle; 0 means storage-only reads.
- CNT_WIDTH, clog2(FIFO_DEPTH)+1: width of the occupancy counters.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- w_val  in  W_PORTS  per-lane write request.
- w_data  in  W_PORTS*FIFO_WIDTH  lane i occupies bits [i*FIFO_WIDTH +: FIFO_WIDTH].
- w_rdy  out  W_PORTS  lane i would be accepted this cycle if valid.
- r_val  in  R_PORTS  per-lane pop request; must be thermometer-coded from lane 0.
- r_data  out  R_PORTS*FIFO_WIDTH  lane j shows the entry at head+j.
- r_avail  out  R_PORTS  lane j holds valid data.
- size  out  CNT_WIDTH  registered occupancy, 0..FIFO_DEPTH.
- free  out  CNT_WIDTH  registered, equal to FIFO_DEPTH - size.
- full  out  1  registered, asserted when size == FIFO_DEPTH.
- empty  out  1  registered, asserted when size == 0.

Behaviour:
- Reset (rst high at an edge):
  - head, tail and used counter go to 0.
  - size=0, free=FIFO_DEPTH, full=0, empty=1.
  - Storage array is not reset.
  - Reset mid-burst discards all contents. The cycle after reset behaves as empty.
- Write compaction:
  - rank_i = popcount(w_val[i-1:0]).
  - w_rdy[i] = (rank_i < free).
  - A lane is accepted when w_val[i] & w_rdy[i].
  - Accepted lanes are written to tail+rank_i (mod FIFO_DEPTH) in ascending lane order, so lane order is program order.
  - nw = number of accepted lanes.
- Write acceptance uses only the registered free count. A pop in the same cycle never frees space for a write (no comb path from r_val to w_rdy).
  - Full + simultaneous read and write: the write is refused and the pop completes.
- Read availability:
  - BYPASS=0: r_avail[j] = (j < size).
  - BYPASS=1: r_avail[j] = (j < size + nw).
  - r_data[j] comes from storage at head+j when j < size. Otherwise, with bypass, it is the (j-size)-th accepted write of this cycle.
  - Unavailable lanes drive all-ones.
- Pop count:
  - nr = number of leading ones of (r_val & r_avail).
  - A non-thermometer r_val pops only the leading contiguous run; a simulation assertion fires.
- Update:
  - head += nr, tail += nw, both wrapping mod FIFO_DEPTH.
  - used_next = used + nw - nr, never negative by construction.
  - size, free, full and empty are all derived from used_next and registered.
- Latency:
  - BYPASS=0: a write at cycle t is first readable at t+1.
  - BYPASS=1: a write at cycle t is readable at t. A bypassed word popped in the same cycle leaves size unchanged.
- Wrap-around: any multi-lane write or read spanning the index FIFO_DEPTH-1 to 0 is contiguous modulo depth.
- Ordering: FIFO order across cycles and across lanes is strict. No entry is lost or duplicated.

Decomposition:
- Shared package fifo_pkg holds:
  - elem_none(width) constant function (all-ones).
  - popcount and leading-ones functions.
  - clog2-safe helper for CNT_WIDTH.
- One sub-module, fifo_lane_compact: from w_val and free it produces rank_i, w_rdy, the accepted mask and nw. It is reused by future multi-port queues.

Test Plan:
- Reset, then idle: size=0, free=16, empty=1, r_avail=00, r_data all-ones. Reset asserted with 5 entries held returns to the same state on the next cycle.
- BYPASS=0, write lanes 0,1 = 0xA,0xB at cycle 0: r_avail=11 at cycle 1, r_data lane0=0xA, lane1=0xB, size=2. Pop r_val=11 gives empty=1 at cycle 2.
- Compaction: w_val=10, lane1 data 0xC, into an empty FIFO: stored at index 0, lane0 reads 0xC next cycle, size=1.
- Fill to 15, then w_val=11: w_rdy=01 (only the first valid lane accepted) and size=16, full=1. Next cycle w_val=11 with r_val=01 gives w_rdy=00, size=15.
- Wrap: head=tail=14, push 4 words over two cycles, then pop 2+2: data order preserved across the 15 to 0 boundary, pointers end at 2.
- BYPASS=1, empty, w_val=01 data 0x5 with r_val=01 same cycle: r_avail=01, r_data lane0=0x5, size stays 0. r_val=10 fires the assertion and pops nothing.
